// File: rtl/armleocpu_ptw_pkg.sv
// Shared constants for the Sv32 page table walker: PTE bit positions, bus response
// codes, TLB command encodings and walker state encoding.
package armleocpu_ptw_pkg;

    localparam int PTE_V = 0;
    localparam int PTE_R = 1;
    localparam int PTE_W = 2;
    localparam int PTE_X = 3;
    localparam int PTE_U = 4;
    localparam int PTE_G = 5;
    localparam int PTE_A = 6;
    localparam int PTE_D = 7;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] TLB_CMD_NONE       = 2'b00;
    localparam logic [1:0] TLB_CMD_RESOLVE    = 2'b01;
    localparam logic [1:0] TLB_CMD_NEW_ENTRY  = 2'b10;
    localparam logic [1:0] TLB_CMD_INVALIDATE = 2'b11;

    typedef enum logic [1:0] {
        PTW_IDLE   = 2'd0,
        PTW_ISSUE  = 2'd1,
        PTW_WAIT   = 2'd2,
        PTW_RESULT = 2'd3
    } ptw_state_t;

    // Byte address of entry 'idx' in the page table located at physical page 'ppn'.
    function automatic logic [33:0] pte_addr(input logic [21:0] ppn, input logic [9:0] idx);
        return {ppn, 12'b0} + {22'b0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/armleocpu_ptw.sv
// Sv32 two-level hardware page table walker; resolves a VPN to a physical tag and
// installs the result into the TLB with a single NEW_ENTRY command.
module armleocpu_ptw
    import armleocpu_ptw_pkg::*;
(
    input  logic        clk,
    input  logic        rst,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic [19:0] req_vaddr,
    input  logic [21:0] satp_ppn,

    output logic        done,
    output logic        pagefault,
    output logic        access_fault,
    output logic [21:0] resolve_ptag,
    output logic [7:0]  resolve_metadata,

    output logic        mem_arvalid,
    input  logic        mem_arready,
    output logic [33:0] mem_araddr,
    input  logic        mem_rvalid,
    output logic        mem_rready,
    input  logic [1:0]  mem_rresp,
    input  logic [31:0] mem_rdata,

    output logic [1:0]  tlb_cmd,
    output logic [19:0] tlb_vaddr,
    output logic [21:0] tlb_new_entry_ptag,
    output logic [7:0]  tlb_new_entry_metadata
);

    ptw_state_t  state_q, state_d;
    logic        level_q, level_d;
    logic [19:0] vpn_q, vpn_d;
    logic [33:0] addr_q, addr_d;
    logic        pf_q, pf_d;
    logic        af_q, af_d;
    logic [21:0] ptag_q, ptag_d;
    logic [7:0]  meta_q, meta_d;

    logic [21:0] pte_ppn;
    logic        pte_v, pte_r, pte_w, pte_x;
    logic        pte_leaf;
    logic        unused_rsw;

    assign pte_ppn    = mem_rdata[31:10];
    assign pte_v      = mem_rdata[PTE_V];
    assign pte_r      = mem_rdata[PTE_R];
    assign pte_w      = mem_rdata[PTE_W];
    assign pte_x      = mem_rdata[PTE_X];
    assign pte_leaf   = pte_r | pte_x;
    assign unused_rsw = ^mem_rdata[9:8];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= PTW_IDLE;
            level_q <= 1'b1;
            vpn_q   <= '0;
            addr_q  <= '0;
            pf_q    <= 1'b0;
            af_q    <= 1'b0;
            ptag_q  <= '0;
            meta_q  <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            vpn_q   <= vpn_d;
            addr_q  <= addr_d;
            pf_q    <= pf_d;
            af_q    <= af_d;
            ptag_q  <= ptag_d;
            meta_q  <= meta_d;
        end
    end

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        vpn_d   = vpn_q;
        addr_d  = addr_q;
        pf_d    = pf_q;
        af_d    = af_q;
        ptag_d  = ptag_q;
        meta_d  = meta_q;

        unique case (state_q)
            PTW_IDLE: begin
                if (req_valid) begin
                    vpn_d   = req_vaddr;
                    level_d = 1'b1;
                    addr_d  = pte_addr(satp_ppn, req_vaddr[19:10]);
                    pf_d    = 1'b0;
                    af_d    = 1'b0;
                    state_d = PTW_ISSUE;
                end
            end
            PTW_ISSUE: begin
                if (mem_arready) begin
                    state_d = PTW_WAIT;
                end
            end
            PTW_WAIT: begin
                if (mem_rvalid) begin
                    state_d = PTW_RESULT;
                    if (mem_rresp != RESP_OKAY) begin
                        af_d = 1'b1;
                    end else if (!pte_v || (!pte_r && pte_w)) begin
                        pf_d = 1'b1;
                    end else if (pte_leaf) begin
                        // A level-1 leaf maps a 4 MiB megapage, so its low PPN must be zero.
                        if (level_q && (pte_ppn[9:0] != 10'd0)) begin
                            pf_d = 1'b1;
                        end else begin
                            ptag_d = level_q ? {pte_ppn[21:10], vpn_q[9:0]} : pte_ppn;
                            meta_d = mem_rdata[7:0];
                        end
                    end else if (level_q) begin
                        level_d = 1'b0;
                        addr_d  = pte_addr(pte_ppn, vpn_q[9:0]);
                        state_d = PTW_ISSUE;
                    end else begin
                        pf_d = 1'b1;
                    end
                end
            end
            PTW_RESULT: begin
                state_d = PTW_IDLE;
            end
            default: begin
                state_d = PTW_IDLE;
            end
        endcase
    end

    assign req_ready              = (state_q == PTW_IDLE);
    assign mem_arvalid            = (state_q == PTW_ISSUE);
    assign mem_rready             = (state_q == PTW_WAIT);
    assign done                   = (state_q == PTW_RESULT);
    assign mem_araddr             = addr_q;
    assign pagefault              = pf_q;
    assign access_fault           = af_q;
    assign resolve_ptag           = ptag_q;
    assign resolve_metadata       = meta_q;
    assign tlb_cmd                = (done && !pf_q && !af_q) ? TLB_CMD_NEW_ENTRY : TLB_CMD_NONE;
    assign tlb_vaddr              = vpn_q;
    assign tlb_new_entry_ptag     = ptag_q;
    assign tlb_new_entry_metadata = meta_q;

endmodule

// File: tb/tb_armleocpu_ptw.sv
// Directed bench for the Sv32 page table walker with a small scripted PTE memory.
module tb_armleocpu_ptw;
    import armleocpu_ptw_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [19:0] req_vaddr = '0;
    logic [21:0] satp_ppn = '0;
    logic        done, pagefault, access_fault;
    logic [21:0] resolve_ptag;
    logic [7:0]  resolve_metadata;
    logic        mem_arvalid;
    logic        mem_arready = 1'b0;
    logic [33:0] mem_araddr;
    logic        mem_rvalid = 1'b0;
    logic        mem_rready;
    logic [1:0]  mem_rresp = 2'b00;
    logic [31:0] mem_rdata = '0;
    logic [1:0]  tlb_cmd;
    logic [19:0] tlb_vaddr;
    logic [21:0] tlb_new_entry_ptag;
    logic [7:0]  tlb_new_entry_metadata;

    int errors = 0;
    int checks = 0;

    logic [33:0] exp_addr [0:1];
    logic [31:0] rd_data  [0:1];
    logic [1:0]  rd_resp  [0:1];
    int          rd_idx = 0;
    int          stall_left = 0;
    logic        hold_r = 1'b0;
    int          tlb_cnt = 0;
    int          done_cnt = 0;

    always #5 clk = ~clk;

    armleocpu_ptw dut (
        .clk                    (clk),
        .rst                    (rst),
        .req_valid              (req_valid),
        .req_ready              (req_ready),
        .req_vaddr              (req_vaddr),
        .satp_ppn               (satp_ppn),
        .done                   (done),
        .pagefault              (pagefault),
        .access_fault           (access_fault),
        .resolve_ptag           (resolve_ptag),
        .resolve_metadata       (resolve_metadata),
        .mem_arvalid            (mem_arvalid),
        .mem_arready            (mem_arready),
        .mem_araddr             (mem_araddr),
        .mem_rvalid             (mem_rvalid),
        .mem_rready             (mem_rready),
        .mem_rresp              (mem_rresp),
        .mem_rdata              (mem_rdata),
        .tlb_cmd                (tlb_cmd),
        .tlb_vaddr              (tlb_vaddr),
        .tlb_new_entry_ptag     (tlb_new_entry_ptag),
        .tlb_new_entry_metadata (tlb_new_entry_metadata)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scripted memory: responds on the falling edge so the DUT sees stable inputs.
    always @(negedge clk) begin
        mem_arready = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rresp   = 2'b00;
        if (!rst && rd_idx < 2) begin
            if (mem_arvalid) begin
                chk("araddr", {30'b0, mem_araddr}, {30'b0, exp_addr[rd_idx]});
                if (stall_left > 0) stall_left--;
                else mem_arready = 1'b1;
            end
            if (mem_rready && !hold_r) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rd_data[rd_idx];
                mem_rresp  = rd_resp[rd_idx];
                rd_idx++;
            end
        end
    end

    always @(posedge clk) begin
        if (tlb_cmd == TLB_CMD_NEW_ENTRY) tlb_cnt++;
        if (done) done_cnt++;
    end

    task automatic setup_rd(input int i, input logic [33:0] a, input logic [31:0] d, input logic [1:0] r);
        exp_addr[i] = a;
        rd_data[i]  = d;
        rd_resp[i]  = r;
    endtask

    task automatic walk(input string name, input logic [21:0] satp, input logic [19:0] va,
                        input int exp_lat, input int exp_reads, input logic exp_pf, input logic exp_af,
                        input logic [21:0] exp_ptag, input logic [7:0] exp_meta);
        int edges;
        int tlb0;
        logic ok;
        ok = !exp_pf && !exp_af;
        rd_idx = 0;
        tlb0 = tlb_cnt;
        @(negedge clk);
        req_valid = 1'b1;
        req_vaddr = va;
        satp_ppn  = satp;
        @(posedge clk);
        edges = 1;
        #1;
        req_valid = 1'b0;
        while (!done && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
        chk({name, " latency"}, edges, exp_lat);
        chk({name, " reads"}, rd_idx, exp_reads);
        chk({name, " pagefault"}, {63'b0, pagefault}, {63'b0, exp_pf});
        chk({name, " access_fault"}, {63'b0, access_fault}, {63'b0, exp_af});
        chk({name, " tlb_cmd"}, {62'b0, tlb_cmd}, ok ? {62'b0, TLB_CMD_NEW_ENTRY} : {62'b0, TLB_CMD_NONE});
        if (ok) begin
            chk({name, " ptag"}, {42'b0, resolve_ptag}, {42'b0, exp_ptag});
            chk({name, " metadata"}, {56'b0, resolve_metadata}, {56'b0, exp_meta});
            chk({name, " tlb_vaddr"}, {44'b0, tlb_vaddr}, {44'b0, va});
            chk({name, " tlb_ptag"}, {42'b0, tlb_new_entry_ptag}, {42'b0, exp_ptag});
            chk({name, " tlb_meta"}, {56'b0, tlb_new_entry_metadata}, {56'b0, exp_meta});
        end
        @(posedge clk);
        #1;
        chk({name, " done pulse"}, {63'b0, done}, 64'd0);
        chk({name, " req_ready"}, {63'b0, req_ready}, 64'd1);
        chk({name, " tlb writes"}, tlb_cnt - tlb0, ok ? 64'd1 : 64'd0);
    endtask

    initial begin
        int n;
        int done0, tlb0;
        #2;
        chk("rst req_ready", {63'b0, req_ready}, 64'd1);
        chk("rst done", {63'b0, done}, 64'd0);
        chk("rst arvalid", {63'b0, mem_arvalid}, 64'd0);
        chk("rst rready", {63'b0, mem_rready}, 64'd0);
        chk("rst faults", {62'b0, pagefault, access_fault}, 64'd0);
        chk("rst tlb_cmd", {62'b0, tlb_cmd}, {62'b0, TLB_CMD_NONE});
        chk("rst araddr", {30'b0, mem_araddr}, 64'd0);
        chk("rst ptag", {42'b0, resolve_ptag}, 64'd0);
        chk("rst tlb_vaddr", {44'b0, tlb_vaddr}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        setup_rd(0, 34'h1004, 32'h801, 2'b00);
        setup_rd(1, 34'h2004, 32'h3D4CF, 2'b00);
        walk("page4k", 22'h1, 20'h00401, 5, 2, 1'b0, 1'b0, 22'hF5, 8'hCF);

        setup_rd(0, 34'h100C, 32'h1000CF, 2'b00);
        walk("mega", 22'h1, 20'h00C05, 3, 1, 1'b0, 1'b0, 22'h405, 8'hCF);

        setup_rd(0, 34'h100C, 32'h1004CF, 2'b00);
        walk("misaligned", 22'h1, 20'h00C05, 3, 1, 1'b1, 1'b0, 22'h0, 8'h0);

        setup_rd(0, 34'h100C, 32'h0, 2'b00);
        walk("invalid", 22'h1, 20'h00C05, 3, 1, 1'b1, 1'b0, 22'h0, 8'h0);

        setup_rd(0, 34'h100C, 32'h5, 2'b00);
        walk("w_no_r", 22'h1, 20'h00C05, 3, 1, 1'b1, 1'b0, 22'h0, 8'h0);

        setup_rd(0, 34'h1004, 32'h801, 2'b00);
        setup_rd(1, 34'h2004, 32'h801, 2'b00);
        walk("nonleaf_l0", 22'h1, 20'h00401, 5, 2, 1'b1, 1'b0, 22'h0, 8'h0);

        setup_rd(0, 34'h1004, 32'h801, 2'b00);
        setup_rd(1, 34'h2004, 32'h3D4CF, 2'b10);
        walk("bus_err", 22'h1, 20'h00401, 5, 2, 1'b0, 1'b1, 22'h0, 8'h0);

        stall_left = 4;
        setup_rd(0, 34'h100C, 32'h1000CF, 2'b00);
        walk("backpressure", 22'h1, 20'h00C05, 7, 1, 1'b0, 1'b0, 22'h405, 8'hCF);

        setup_rd(0, 34'h3_FFFF_FFFC, 32'hFFFF_FC01, 2'b00);
        setup_rd(1, 34'h3_FFFF_FFFC, 32'h0AAF_34FF, 2'b00);
        walk("high_addr", 22'h3FFFFF, 20'hFFFFF, 5, 2, 1'b0, 1'b0, 22'h2ABCD, 8'hFF);

        // Reset while parked in WAIT must abort the walk silently.
        hold_r = 1'b1;
        rd_idx = 0;
        setup_rd(0, 34'h1004, 32'h801, 2'b00);
        done0 = done_cnt;
        tlb0  = tlb_cnt;
        @(negedge clk);
        req_valid = 1'b1;
        req_vaddr = 20'h00401;
        satp_ppn  = 22'h1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n = 0;
        while (!mem_rready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("reach wait", {63'b0, mem_rready}, 64'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst req_ready", {63'b0, req_ready}, 64'd1);
        chk("midrst arvalid", {63'b0, mem_arvalid}, 64'd0);
        chk("midrst done", {63'b0, done}, 64'd0);
        @(posedge clk);
        #1;
        chk("midrst next req_ready", {63'b0, req_ready}, 64'd1);
        chk("midrst next rready", {63'b0, mem_rready}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        hold_r = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("midrst no done", done_cnt - done0, 64'd0);
        chk("midrst no tlb", tlb_cnt - tlb0, 64'd0);
        chk("midrst idle", {63'b0, req_ready}, 64'd1);

        setup_rd(0, 34'h1004, 32'h801, 2'b00);
        setup_rd(1, 34'h2004, 32'h3D4CF, 2'b00);
        walk("after_rst", 22'h1, 20'h00401, 5, 2, 1'b0, 1'b0, 22'hF5, 8'hCF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
